// File: rtl/s247_pathfinder_pkg.sv
// Shared definitions for the S247 geofence job master.
// Holds the register map of the pathfinder slave (byte offsets from its base),
// the response code and job step enumerations, the master FSM states, and small
// helpers that map a step to its register offset and bus direction.
package s247_pathfinder_pkg;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_STATUS    = 8'h04;
  localparam logic [7:0] REG_GPS_LAT   = 8'h08;
  localparam logic [7:0] REG_GPS_LON   = 8'h0C;
  localparam logic [7:0] REG_FENCE_LAT = 8'h10;
  localparam logic [7:0] REG_FENCE_LON = 8'h14;
  localparam logic [7:0] REG_FENCE_RAD = 8'h18;
  localparam logic [7:0] REG_RESULT    = 8'h1C;

  typedef enum logic [1:0] {
    RSP_OK           = 2'd0,
    RSP_HALT         = 2'd1,
    RSP_BUS_TIMEOUT  = 2'd2,
    RSP_POLL_TIMEOUT = 2'd3
  } rsp_code_t;

  // Order matters: the configuration steps advance by increment into STATUS.
  typedef enum logic [3:0] {
    STEP_GPS_LAT,
    STEP_GPS_LON,
    STEP_FENCE_LAT,
    STEP_FENCE_LON,
    STEP_FENCE_RAD,
    STEP_ARM,
    STEP_STATUS,
    STEP_RESULT,
    STEP_DISARM
  } step_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_GAP,
    ST_EVAL,
    ST_POLL_WAIT,
    ST_RESP
  } state_t;

  function automatic logic [7:0] step_offset(input step_t step);
    case (step)
      STEP_GPS_LAT:   return REG_GPS_LAT;
      STEP_GPS_LON:   return REG_GPS_LON;
      STEP_FENCE_LAT: return REG_FENCE_LAT;
      STEP_FENCE_LON: return REG_FENCE_LON;
      STEP_FENCE_RAD: return REG_FENCE_RAD;
      STEP_STATUS:    return REG_STATUS;
      STEP_RESULT:    return REG_RESULT;
      default:        return REG_CTRL;
    endcase
  endfunction

  function automatic logic step_is_write(input step_t step);
    return !((step == STEP_STATUS) || (step == STEP_RESULT));
  endfunction

endpackage

// File: rtl/s247_wb_master_port.sv
// Single-transaction Wishbone classic engine.
// The sequencer holds req high for the whole cycle; cyc/stb follow req, so the
// bus cycle ends the cycle after done or timeout is seen (req is a registered
// state decode in the top). Address/data/sel are forced to 0 outside a cycle.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req, we, adr, dat         transaction request (level) and its attributes
//   bus_*                     Wishbone master signals
//   done                      ack seen this cycle while stb is high
//   rdata                     read data latched on the ack cycle
//   timeout                   ACK_TIMEOUT cycles of stb without ack
module s247_wb_master_port #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic [DATA_WIDTH-1:0] dat,
  output logic                  bus_cyc,
  output logic                  bus_stb,
  output logic                  bus_we,
  output logic [3:0]            bus_sel,
  output logic [ADDR_WIDTH-1:0] bus_adr,
  output logic [DATA_WIDTH-1:0] bus_wdat,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdat,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  timeout
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0]         ack_cnt_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  assign bus_cyc  = req;
  assign bus_stb  = req;
  assign bus_we   = req & we;
  assign bus_sel  = req ? 4'hF : 4'h0;
  assign bus_adr  = req ? adr : '0;
  assign bus_wdat = req ? dat : '0;

  assign done    = req & bus_ack;
  // Counter reads 0 in the first stb cycle, so firing at ACK_TIMEOUT-1 keeps
  // stb high for exactly ACK_TIMEOUT cycles.
  assign timeout = req & ~bus_ack & (ack_cnt_reg >= CW'(ACK_TIMEOUT - 1));
  assign rdata   = rdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_cnt_reg <= '0;
      rdata_reg   <= '0;
    end else begin
      if (!req) begin
        ack_cnt_reg <= '0;
      end else if (ack_cnt_reg < CW'(ACK_TIMEOUT)) begin
        ack_cnt_reg <= ack_cnt_reg + 1'b1;
      end
      if (done) begin
        rdata_reg <= bus_rdat;
      end
    end
  end

endmodule

// File: rtl/s247_geofence_job_master.sv
// Geofence job master: accepts one job from the host, programs the S247
// pathfinder slave over Wishbone, arms the selected cores, polls STATUS until
// the masked cores finish or any core halts, fetches RESULT, disarms, and
// returns a response. One job in flight at a time.
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   job_*                     host job request (valid/ready + fields)
//   wbm_*                     Wishbone classic master
//   rsp_*                     response (valid held until ready)
//   busy_o                    job in flight or response pending
module s247_geofence_job_master
  import s247_pathfinder_pkg::*;
#(
  parameter int                  NUM_CORES   = 8,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h3000_0000,
  parameter int                  ACK_TIMEOUT = 64,
  parameter int                  POLL_GAP    = 16,
  parameter int                  MAX_POLLS   = 1024
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [DATA_WIDTH-1:0] job_gps_lat_i,
  input  logic [DATA_WIDTH-1:0] job_gps_lon_i,
  input  logic [DATA_WIDTH-1:0] job_fence_lat_i,
  input  logic [DATA_WIDTH-1:0] job_fence_lon_i,
  input  logic [DATA_WIDTH-1:0] job_fence_rad_i,
  input  logic [NUM_CORES-1:0]  job_core_mask_i,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  input  logic                  wbm_ack_i,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [1:0]            rsp_code_o,
  output logic [DATA_WIDTH-1:0] rsp_result_o,
  output logic [DATA_WIDTH-1:0] rsp_status_o,
  output logic                  busy_o
);

  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  state_t                state_reg, state_next;
  step_t                 step_reg;
  rsp_code_t             code_reg;
  logic [DATA_WIDTH-1:0] lat_reg, lon_reg, flat_reg, flon_reg, frad_reg;
  logic [NUM_CORES-1:0]  mask_reg;
  logic [DATA_WIDTH-1:0] result_reg, status_reg;
  logic [PW-1:0]         poll_cnt_reg;
  logic [GW-1:0]         gap_cnt_reg;

  logic                  port_req, port_done, port_timeout;
  logic [DATA_WIDTH-1:0] port_rdata, step_wdata;
  logic                  any_halt, mask_done, poll_limit;

  assign any_halt   = |status_reg[2*NUM_CORES-1:NUM_CORES];
  assign mask_done  = (status_reg[NUM_CORES-1:0] & mask_reg) == mask_reg;
  assign poll_limit = poll_cnt_reg >= PW'(MAX_POLLS);

  always_comb begin
    step_wdata = '0;
    case (step_reg)
      STEP_GPS_LAT:   step_wdata = lat_reg;
      STEP_GPS_LON:   step_wdata = lon_reg;
      STEP_FENCE_LAT: step_wdata = flat_reg;
      STEP_FENCE_LON: step_wdata = flon_reg;
      STEP_FENCE_RAD: step_wdata = frad_reg;
      STEP_ARM:       step_wdata[NUM_CORES-1:0] = mask_reg;
      default:        step_wdata = '0;
    endcase
  end

  s247_wb_master_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_port (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .req     (port_req),
    .we      (step_is_write(step_reg)),
    .adr     (BASE_ADDR + ADDR_WIDTH'(step_offset(step_reg))),
    .dat     (step_wdata),
    .bus_cyc (wbm_cyc_o),
    .bus_stb (wbm_stb_o),
    .bus_we  (wbm_we_o),
    .bus_sel (wbm_sel_o),
    .bus_adr (wbm_adr_o),
    .bus_wdat(wbm_dat_o),
    .bus_ack (wbm_ack_i),
    .bus_rdat(wbm_dat_i),
    .done    (port_done),
    .rdata   (port_rdata),
    .timeout (port_timeout)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (job_valid_i) state_next = ST_ISSUE;
      ST_ISSUE,
      ST_WAIT_ACK: begin
        if (port_done)         state_next = ST_GAP;
        else if (port_timeout) state_next = ST_RESP;  // abort skips the disarm
        else                   state_next = ST_WAIT_ACK;
      end
      ST_GAP: begin
        if (step_reg == STEP_STATUS)      state_next = ST_EVAL;
        else if (step_reg == STEP_DISARM) state_next = ST_RESP;
        else                              state_next = ST_ISSUE;
      end
      ST_EVAL: begin
        if (any_halt || mask_done || poll_limit) state_next = ST_ISSUE;
        else                                     state_next = ST_POLL_WAIT;
      end
      // GAP + EVAL + (POLL_GAP-1) wait cycles separate consecutive polls.
      ST_POLL_WAIT: if (gap_cnt_reg >= GW'(POLL_GAP - 2)) state_next = ST_ISSUE;
      ST_RESP:      if (rsp_ready_i) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    port_req     = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT_ACK);
    job_ready_o  = (state_reg == ST_IDLE) && !wb_rst_i;
    rsp_valid_o  = (state_reg == ST_RESP);
    busy_o       = (state_reg != ST_IDLE);
    rsp_code_o   = rsp_valid_o ? code_reg : 2'd0;
    rsp_result_o = (rsp_valid_o && code_reg == RSP_OK) ? result_reg : '0;
    rsp_status_o = rsp_valid_o ? status_reg : '0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      step_reg     <= STEP_GPS_LAT;
      code_reg     <= RSP_OK;
      lat_reg      <= '0;
      lon_reg      <= '0;
      flat_reg     <= '0;
      flon_reg     <= '0;
      frad_reg     <= '0;
      mask_reg     <= '0;
      result_reg   <= '0;
      status_reg   <= '0;
      poll_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (job_valid_i) begin
          lat_reg      <= job_gps_lat_i;
          lon_reg      <= job_gps_lon_i;
          flat_reg     <= job_fence_lat_i;
          flon_reg     <= job_fence_lon_i;
          frad_reg     <= job_fence_rad_i;
          mask_reg     <= job_core_mask_i;
          step_reg     <= STEP_GPS_LAT;
          code_reg     <= RSP_OK;
          result_reg   <= '0;
          status_reg   <= '0;
          poll_cnt_reg <= '0;
        end
        ST_ISSUE,
        ST_WAIT_ACK: if (port_timeout) code_reg <= RSP_BUS_TIMEOUT;
        ST_GAP: begin
          case (step_reg)
            STEP_STATUS: begin
              status_reg <= port_rdata;
              if (!poll_limit) poll_cnt_reg <= poll_cnt_reg + 1'b1;
            end
            STEP_RESULT: begin
              result_reg <= port_rdata;
              step_reg   <= STEP_DISARM;
            end
            STEP_DISARM: ;
            default: step_reg <= step_t'(step_reg + 1'b1);
          endcase
        end
        ST_EVAL: begin
          // Halt wins over done when both appear in the same STATUS read.
          if (any_halt) begin
            code_reg <= RSP_HALT;
            step_reg <= STEP_DISARM;
          end else if (mask_done) begin
            step_reg <= STEP_RESULT;
          end else if (poll_limit) begin
            code_reg <= RSP_POLL_TIMEOUT;
            step_reg <= STEP_DISARM;
          end else begin
            gap_cnt_reg <= '0;
          end
        end
        ST_POLL_WAIT: gap_cnt_reg <= gap_cnt_reg + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s247_geofence_job_master.sv
module tb_s247_geofence_job_master;

  localparam int ACK_TIMEOUT = 64;
  localparam int POLL_GAP    = 16;
  localparam int MAX_POLLS   = 4;

  localparam logic [31:0] A_CTRL   = 32'h3000_0000;
  localparam logic [31:0] A_STATUS = 32'h3000_0004;
  localparam logic [31:0] A_LAT    = 32'h3000_0008;
  localparam logic [31:0] A_LON    = 32'h3000_000C;
  localparam logic [31:0] A_FLAT   = 32'h3000_0010;
  localparam logic [31:0] A_FLON   = 32'h3000_0014;
  localparam logic [31:0] A_FRAD   = 32'h3000_0018;
  localparam logic [31:0] A_RES    = 32'h3000_001C;

  localparam logic [31:0] J_LAT  = 32'h0001_8000;
  localparam logic [31:0] J_LON  = 32'hFFFE_0000;
  localparam logic [31:0] J_FLAT = 32'h0001_0000;
  localparam logic [31:0] J_FLON = 32'hFFFF_0000;
  localparam logic [31:0] J_RAD  = 32'h0000_0400;
  localparam logic [31:0] RES_VAL = 32'hCAFE_0123;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } tx_t;

  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] result;
    logic [31:0] status;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_gps_lat = '0, job_gps_lon = '0, job_fence_lat = '0;
  logic [31:0] job_fence_lon = '0, job_fence_rad = '0;
  logic [7:0]  job_core_mask = '0;
  logic        wbm_cyc, wbm_stb, wbm_we;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr, wbm_dat_o;
  logic        wbm_ack = 1'b0;
  logic [31:0] wbm_dat_i = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_result, rsp_status;
  logic        busy;

  tx_t  exp_tx_q[$];
  rsp_t exp_rsp_q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   stb_rises = 0;

  int          slv_done_at = 1000;
  logic [31:0] slv_done_val = '0;
  logic [31:0] slv_noack_adr = 32'hFFFF_FFFF;
  int          slv_lat = 1;
  int          slv_polls = 0;

  s247_geofence_job_master #(
    .NUM_CORES  (8),
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .BASE_ADDR  (32'h3000_0000),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .POLL_GAP   (POLL_GAP),
    .MAX_POLLS  (MAX_POLLS)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .job_valid_i    (job_valid),
    .job_ready_o    (job_ready),
    .job_gps_lat_i  (job_gps_lat),
    .job_gps_lon_i  (job_gps_lon),
    .job_fence_lat_i(job_fence_lat),
    .job_fence_lon_i(job_fence_lon),
    .job_fence_rad_i(job_fence_rad),
    .job_core_mask_i(job_core_mask),
    .wbm_cyc_o      (wbm_cyc),
    .wbm_stb_o      (wbm_stb),
    .wbm_we_o       (wbm_we),
    .wbm_sel_o      (wbm_sel),
    .wbm_adr_o      (wbm_adr),
    .wbm_dat_o      (wbm_dat_o),
    .wbm_ack_i      (wbm_ack),
    .wbm_dat_i      (wbm_dat_i),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_code_o     (rsp_code),
    .rsp_result_o   (rsp_result),
    .rsp_status_o   (rsp_status),
    .busy_o         (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Slave model: acks after slv_lat stb cycles, STATUS returns slv_done_val
  // from poll number slv_done_at onward, never acks slv_noack_adr.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (wbm_cyc && wbm_stb && !wbm_ack && wbm_adr != slv_noack_adr) begin
        wcnt++;
        if (wcnt >= slv_lat) begin
          wcnt = 0;
          wbm_ack = 1'b1;
          if (wbm_adr == A_STATUS) begin
            slv_polls++;
            wbm_dat_i = (slv_polls >= slv_done_at) ? slv_done_val : 32'h0;
          end else if (wbm_adr == A_RES) begin
            wbm_dat_i = RES_VAL;
          end else begin
            wbm_dat_i = 32'h0;
          end
        end
      end else begin
        wbm_ack = 1'b0;
        if (!wbm_stb) wcnt = 0;
      end
    end
  end

  // Bus monitor: compares each acked transaction and the idle spacing between polls.
  initial begin
    int   idle;
    logic prev_status;
    logic prev_stb;
    tx_t  e;
    idle = 0;
    prev_status = 1'b0;
    prev_stb = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (wbm_stb && !prev_stb) stb_rises++;
      prev_stb = wbm_stb;
      if (!wbm_stb) begin
        idle++;
      end else if (wbm_ack) begin
        $display("tx %s adr=%08h dat=%08h sel=%h", wbm_we ? "W" : "R", wbm_adr,
                 wbm_we ? wbm_dat_o : wbm_dat_i, wbm_sel);
        if (wbm_adr == A_STATUS && prev_status) begin
          nvec++;
          if (idle != POLL_GAP + 1) begin
            nerr++;
            $display("FAIL poll_gap: got %0d idle cycles, need %0d", idle, POLL_GAP + 1);
          end
        end
        prev_status = (wbm_adr == A_STATUS);
        idle = 0;
        nvec++;
        if (exp_tx_q.size() == 0) begin
          nerr++;
          $display("FAIL bus_tx: unexpected %s at %08h", wbm_we ? "W" : "R", wbm_adr);
        end else begin
          e = exp_tx_q.pop_front();
          if (wbm_we != e.we || wbm_adr != e.adr || wbm_sel != 4'hF ||
              (e.we && wbm_dat_o != e.dat)) begin
            nerr++;
            $display("FAIL bus_tx: got we=%0b adr=%08h dat=%08h sel=%h, need we=%0b adr=%08h dat=%08h sel=f",
                     wbm_we, wbm_adr, wbm_dat_o, wbm_sel, e.we, e.adr, e.dat);
          end
        end
      end
    end
  end

  // Response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_valid && rsp_ready) begin
        $display("rsp code=%0d result=%08h status=%08h", rsp_code, rsp_result, rsp_status);
        nvec++;
        if (exp_rsp_q.size() == 0) begin
          nerr++;
          $display("FAIL rsp: unexpected response code=%0d", rsp_code);
        end else begin
          e = exp_rsp_q.pop_front();
          if (rsp_code != e.code || rsp_result != e.result || rsp_status != e.status) begin
            nerr++;
            $display("FAIL rsp: got code=%0d result=%08h status=%08h, need code=%0d result=%08h status=%08h",
                     rsp_code, rsp_result, rsp_status, e.code, e.result, e.status);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    nvec++;
    if (got !== need) begin
      nerr++;
      $display("FAIL %s: got %08h, need %08h", name, got, need);
    end
  endtask

  task automatic push_wr(input logic [31:0] adr, input logic [31:0] dat);
    exp_tx_q.push_back('{we: 1'b1, adr: adr, dat: dat});
  endtask

  task automatic push_rd(input logic [31:0] adr);
    exp_tx_q.push_back('{we: 1'b0, adr: adr, dat: 32'h0});
  endtask

  task automatic push_cfg(input logic [7:0] mask);
    push_wr(A_LAT, J_LAT);
    push_wr(A_LON, J_LON);
    push_wr(A_FLAT, J_FLAT);
    push_wr(A_FLON, J_FLON);
    push_wr(A_FRAD, J_RAD);
    push_wr(A_CTRL, {24'h0, mask});
  endtask

  task automatic push_rsp(input logic [1:0] code, input logic [31:0] res, input logic [31:0] st);
    exp_rsp_q.push_back('{code: code, result: res, status: st});
  endtask

  task automatic slave_cfg(input int done_at, input logic [31:0] done_val,
                           input logic [31:0] noack, input int lat);
    slv_done_at   = done_at;
    slv_done_val  = done_val;
    slv_noack_adr = noack;
    slv_lat       = lat;
    slv_polls     = 0;
  endtask

  task automatic drive_job(input logic [7:0] mask);
    job_gps_lat   = J_LAT;
    job_gps_lon   = J_LON;
    job_fence_lat = J_FLAT;
    job_fence_lon = J_FLON;
    job_fence_rad = J_RAD;
    job_core_mask = mask;
    job_valid     = 1'b1;
  endtask

  task automatic scramble_job();
    job_valid     = 1'b0;
    job_gps_lat   = 32'hDEAD_BEEF;
    job_gps_lon   = 32'hDEAD_BEEF;
    job_fence_lat = 32'hDEAD_BEEF;
    job_fence_lon = 32'hDEAD_BEEF;
    job_fence_rad = 32'hDEAD_BEEF;
    job_core_mask = 8'hA5;
  endtask

  task automatic run_job(input logic [7:0] mask);
    int n;
    @(negedge clk);
    drive_job(mask);
    n = 0;
    while (!job_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("job_accept", {31'h0, job_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    scramble_job();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_rsp_q.size() != 0 || busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_finish"}, {31'h0, (exp_rsp_q.size() == 0 && !busy)}, 32'h1);
    check({name, "_tx_left"}, exp_tx_q.size(), 32'h0);
  endtask

  initial begin
    int n;
    int r0;
    logic found;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_job_ready", {31'h0, job_ready}, 32'h0);
    check("rst_cyc_stb", {30'h0, wbm_cyc, wbm_stb}, 32'h0);
    check("rst_adr", wbm_adr, 32'h0);
    check("rst_rsp_busy", {30'h0, rsp_valid, busy}, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'h0, job_ready}, 32'h1);

    // 1: normal completion, done on 3rd poll
    slave_cfg(3, 32'h0000_000F, 32'hFFFF_FFFF, 1);
    push_cfg(8'h0F);
    repeat (3) push_rd(A_STATUS);
    push_rd(A_RES);
    push_wr(A_CTRL, 32'h0);
    push_rsp(2'd0, RES_VAL, 32'h0000_000F);
    run_job(8'h0F);
    check("ok_busy", {31'h0, busy}, 32'h1);
    wait_done("ok");

    // 2: halt on first poll
    slave_cfg(1, 32'h0000_0400, 32'hFFFF_FFFF, 1);
    push_cfg(8'h0F);
    push_rd(A_STATUS);
    push_wr(A_CTRL, 32'h0);
    push_rsp(2'd1, 32'h0, 32'h0000_0400);
    run_job(8'h0F);
    wait_done("halt");

    // 3: no ack on GPS_LON
    slave_cfg(1000, 32'h0, A_LON, 1);
    push_wr(A_LAT, J_LAT);
    push_rsp(2'd2, 32'h0, 32'h0);
    run_job(8'h0F);
    n = 0;
    while (!(wbm_stb && wbm_adr == A_LON) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    n = 0;
    while (wbm_stb && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("ack_timeout_len", n, ACK_TIMEOUT);
    r0 = stb_rises;
    wait_done("bus_to");
    check("bus_to_no_more_cycles", stb_rises, r0);

    // 4: poll timeout
    slave_cfg(1000, 32'h0, 32'hFFFF_FFFF, 1);
    push_cfg(8'h0F);
    repeat (MAX_POLLS) push_rd(A_STATUS);
    push_wr(A_CTRL, 32'h0);
    push_rsp(2'd3, 32'h0, 32'h0);
    run_job(8'h0F);
    wait_done("poll_to");

    // 5: response back-pressure with a new job waiting
    rsp_ready = 1'b0;
    slave_cfg(3, 32'h0000_000F, 32'hFFFF_FFFF, 1);
    push_cfg(8'h0F);
    repeat (3) push_rd(A_STATUS);
    push_rd(A_RES);
    push_wr(A_CTRL, 32'h0);
    push_rsp(2'd0, RES_VAL, 32'h0000_000F);
    run_job(8'h0F);
    n = 0;
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    slave_cfg(3, 32'h0000_000F, 32'hFFFF_FFFF, 1);
    push_cfg(8'h0F);
    repeat (3) push_rd(A_STATUS);
    push_rd(A_RES);
    push_wr(A_CTRL, 32'h0);
    push_rsp(2'd0, RES_VAL, 32'h0000_000F);
    drive_job(8'h0F);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      nvec++;
      if (!(rsp_valid && rsp_code == 2'd0 && rsp_result == RES_VAL && rsp_status == 32'hF)) begin
        nerr++;
        $display("FAIL bp_hold[%0d]: got v=%0b code=%0d res=%08h st=%08h, need v=1 code=0 res=%08h st=0000000f",
                 i, rsp_valid, rsp_code, rsp_result, rsp_status, RES_VAL);
      end
      check("bp_ready_low", {31'h0, job_ready}, 32'h0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_ready_at_handshake", {31'h0, job_ready}, 32'h0);
    @(negedge clk);
    #1;
    check("bp_after_handshake", {30'h0, job_ready, rsp_valid}, 32'h2);
    @(posedge clk);
    @(negedge clk);
    scramble_job();
    wait_done("bp");

    // 6: reset during third poll, then a mask=0 job
    slave_cfg(1000, 32'h0, 32'hFFFF_FFFF, 5);
    push_cfg(8'h0F);
    repeat (2) push_rd(A_STATUS);
    run_job(8'h0F);
    found = 1'b0;
    n = 0;
    while (!found && n < 3000) begin
      @(negedge clk);
      #1;
      if (wbm_stb && wbm_adr == A_STATUS && slv_polls == 2) found = 1'b1;
      n++;
    end
    check("rst_mid_found_poll3", {31'h0, found}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_mid_cyc_stb", {30'h0, wbm_cyc, wbm_stb}, 32'h0);
    check("rst_mid_rsp_ready", {30'h0, rsp_valid, job_ready}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_idle", {30'h0, job_ready, busy}, 32'h2);
    check("rst_mid_tx_left", exp_tx_q.size(), 32'h0);
    slave_cfg(1000, 32'h0, 32'hFFFF_FFFF, 1);
    push_cfg(8'h00);
    push_rd(A_STATUS);
    push_rd(A_RES);
    push_wr(A_CTRL, 32'h0);
    push_rsp(2'd0, RES_VAL, 32'h0);
    run_job(8'h00);
    wait_done("mask0");

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
